// File: rtl/usb_tx_pkg.sv
// Shared definitions for the USB transmit path: bit-stuffer state type and
// the USB run length that triggers a stuffed zero.
package usb_tx_pkg;

   localparam int USB_STUFF_RUN_LENGTH = 6;

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      STUFF
   } tx_stuff_state_t;

endpackage : usb_tx_pkg

// File: rtl/tx_nrzi_encoder.sv
// NRZI line encoder: the level toggles on every 0 data bit and holds on a 1.
// The line rests at J (1) after reset; the caller also uses rst to park it at J between packets.
module tx_nrzi_encoder (
   input  logic clk,
   input  logic rst,
   input  logic bit_strobe,
   input  logic data_in,
   output logic level_out
);

   always_ff @(posedge clk) begin
      if (rst) begin
         level_out <= 1'b1;
      end else if (bit_strobe && !data_in) begin
         level_out <= ~level_out;
      end
   end

endmodule : tx_nrzi_encoder

// File: rtl/tx_bit_stuffer.sv
// USB TX bit stuffer: inserts a 0 after every RUN_LENGTH consecutive ones and stalls
// the shift register for that bit time. Define TX_BITSTUFF_NRZI_EN to NRZI-encode the output.
module tx_bit_stuffer
   import usb_tx_pkg::*;
#(
   parameter int RUN_LENGTH = USB_STUFF_RUN_LENGTH,
   parameter int CNT_W      = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic bit_strobe,
   input  logic packet_active,
   input  logic raw_bit,
   output logic stuffed_bit,
   output logic stuff_stall
);

   localparam logic [CNT_W-1:0] LAST_ONE = CNT_W'(RUN_LENGTH - 1);
   localparam logic [CNT_W-1:0] RUN_CNT  = CNT_W'(RUN_LENGTH);

   tx_stuff_state_t  state_q, state_d;
   logic [CNT_W-1:0] ones_cnt_q, ones_cnt_d;
   logic             stall_q, stall_d;
   logic             data_d;
   logic             take_bit;

   // A strobe only counts while the packet is still active; a falling
   // packet_active in the same cycle wins and the strobe is dropped.
   assign take_bit = bit_strobe & packet_active;

   always_comb begin
      // NOTE: every output of this block gets a default before any branch,
      // so no path can leave a value unassigned and infer a latch.
      state_d    = state_q;
      ones_cnt_d = ones_cnt_q;
      stall_d    = stall_q;
      data_d     = 1'b1;

      if (!packet_active) begin
         state_d    = IDLE;
         ones_cnt_d = '0;
         stall_d    = 1'b0;
      end else if (bit_strobe) begin
         unique case (state_q)
            IDLE, SEND: begin
               data_d  = raw_bit;
               state_d = SEND;
               if (!raw_bit) begin
                  ones_cnt_d = '0;
               end else if (ones_cnt_q >= LAST_ONE) begin
                  ones_cnt_d = RUN_CNT;
                  state_d    = STUFF;
                  stall_d    = 1'b1;
               end else begin
                  ones_cnt_d = ones_cnt_q + 1'b1;
               end
            end
            STUFF: begin
               data_d     = 1'b0;
               ones_cnt_d = '0;
               state_d    = SEND;
               stall_d    = 1'b0;
            end
            default: begin
               state_d    = IDLE;
               ones_cnt_d = '0;
               stall_d    = 1'b0;
            end
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         ones_cnt_q <= '0;
         stall_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         ones_cnt_q <= ones_cnt_d;
         stall_q    <= stall_d;
      end
   end

   assign stuff_stall = stall_q;

`ifdef TX_BITSTUFF_NRZI_EN
   logic enc_rst;

   // Idle and EOP return the line to J, same as reset.
   assign enc_rst = rst | ~packet_active;

   tx_nrzi_encoder u_nrzi (
      .clk        (clk),
      .rst        (enc_rst),
      .bit_strobe (take_bit),
      .data_in    (data_d),
      .level_out  (stuffed_bit)
   );
`else
   always_ff @(posedge clk) begin
      if (rst || !packet_active) begin
         stuffed_bit <= 1'b1;
      end else if (take_bit) begin
         stuffed_bit <= data_d;
      end
   end
`endif

endmodule : tx_bit_stuffer

// File: tb/tb_tx_bit_stuffer.sv
// Self-checking bench for tx_bit_stuffer: a per-strobe stuffing model checked every cycle,
// plus literal output patterns. Define TX_BITSTUFF_NRZI_EN to exercise the NRZI build.
module tb_tx_bit_stuffer;

   localparam int RUN = 6;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic bit_strobe = 1'b0;
   logic packet_active = 1'b0;
   logic raw_bit = 1'b0;
   logic stuffed_bit;
   logic stuff_stall;

   int n_cmp  = 0;
   int n_fail = 0;

   // Model: ones run length, pending stuff, last data bit and NRZI level.
   int   m_run   = 0;
   bit   m_pend  = 1'b0;
   bit   m_data  = 1'b1;
   bit   m_level = 1'b1;

   logic [31:0] cap_bits;
   logic [31:0] cap_stall;

   tx_bit_stuffer #(.RUN_LENGTH(6), .CNT_W(3)) dut (
      .clk           (clk),
      .rst           (rst),
      .bit_strobe    (bit_strobe),
      .packet_active (packet_active),
      .raw_bit       (raw_bit),
      .stuffed_bit   (stuffed_bit),
      .stuff_stall   (stuff_stall)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_cmp++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", name, actual, expected, $time);
      end
   endtask

   function automatic bit exp_out();
`ifdef TX_BITSTUFF_NRZI_EN
      return m_level;
`else
      return m_data;
`endif
   endfunction

   // One clock cycle: apply inputs, advance the model, then check the outputs.
   task automatic step(input logic s, input logic a, input logic r, input logic x);
      bit_strobe    = s;
      packet_active = a;
      raw_bit       = r;
      rst           = x;
      if (x || !a) begin
         m_run = 0; m_pend = 1'b0; m_data = 1'b1; m_level = 1'b1;
      end else if (s) begin
         if (m_pend) begin
            m_data = 1'b0; m_pend = 1'b0; m_run = 0;
         end else begin
            m_data = r;
            m_run  = r ? m_run + 1 : 0;
            if (m_run == RUN) m_pend = 1'b1;
         end
         if (!m_data) m_level = ~m_level;
      end
      @(posedge clk);
      #1;
      check("stuffed_bit", {31'd0, stuffed_bit}, {31'd0, exp_out()});
      check("stuff_stall", {31'd0, stuff_stall}, {31'd0, m_pend});
   endtask

   // Upstream shift register: presents seq (leftmost bit first), holds the bit while
   // stalled, strobes every third cycle and keeps the packet active until stall falls.
   task automatic send_seq(input logic [31:0] seq, input int n);
      int i = 0;
      int guard = 0;
      bit stalled;
      cap_bits  = '0;
      cap_stall = '0;
      while ((i < n || m_pend) && guard < 2 * n + 2) begin
         stalled = m_pend;
         step(1'b1, 1'b1, (i < n) ? seq[n-1-i] : 1'b0, 1'b0);
         cap_bits  = {cap_bits[30:0], stuffed_bit};
         cap_stall = {cap_stall[30:0], stuff_stall};
         if (!stalled) i++;
         guard++;
         step(1'b0, 1'b1, 1'b0, 1'b0);
         step(1'b0, 1'b1, 1'b0, 1'b0);
      end
      check("send_seq_done", guard, (guard < 2 * n + 2) ? guard : 0);
   endtask

   task automatic end_packet();
      step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      step(1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      check("reset_bit", {31'd0, stuffed_bit}, 32'd1);
      check("reset_stall", {31'd0, stuff_stall}, 32'd0);
      step(1'b0, 1'b0, 1'b0, 1'b0);

`ifdef TX_BITSTUFF_NRZI_EN
      send_seq(32'b000000000_010111111, 9);
      check("nrzi_levels", cap_bits[9:0], 10'b0011111110);
      check("nrzi_stall", cap_stall[9:0], 10'b0000000010);
      end_packet();
      check("nrzi_idle_j", {31'd0, stuffed_bit}, 32'd1);
`else
      // Six ones then a data zero: stuffed 0 followed by the data 0.
      send_seq(32'b1111110, 7);
      check("run6_bits", cap_bits[7:0], 8'b11111100);
      check("run6_stall", cap_stall[7:0], 8'b00000100);
      end_packet();

      // Five ones then zero: passes through, never stalls.
      send_seq(32'b111110, 6);
      check("run5_bits", cap_bits[5:0], 6'b111110);
      check("run5_stall", cap_stall[5:0], 6'b000000);
      end_packet();

      // Twelve ones: two stuffs, two single-bit-time stall pulses.
      send_seq(32'hFFF, 12);
      check("run12_bits", cap_bits[13:0], 14'b11111101111110);
      check("run12_stall", cap_stall[13:0], 14'b00000100000010);
      end_packet();
`endif

      // Mid-stream reset: three ones, reset two cycles, then a fresh packet.
      send_seq(32'b111, 3);
      step(1'b0, 1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b0, 1'b1);
      check("midrst_bit", {31'd0, stuffed_bit}, 32'd1);
      check("midrst_stall", {31'd0, stuff_stall}, 32'd0);
      send_seq(32'b11111, 5);
      check("postrst_stall", cap_stall[4:0], 5'b00000);
      end_packet();

      // Abort: packet_active drops the cycle after stall rises.
      for (int k = 0; k < RUN; k++) begin
         step(1'b1, 1'b1, 1'b1, 1'b0);
         step(1'b0, 1'b1, 1'b0, 1'b0);
      end
      check("abort_stall_up", {31'd0, stuff_stall}, 32'd1);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      check("abort_bit", {31'd0, stuffed_bit}, 32'd1);
      check("abort_stall", {31'd0, stuff_stall}, 32'd0);
      send_seq(32'b11111, 5);
      check("abort_next_stall", cap_stall[4:0], 5'b00000);

      // Strobe in the same cycle packet_active falls is dropped.
      step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      check("strobe_eop_bit", {31'd0, stuffed_bit}, 32'd1);
      end_packet();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule : tb_tx_bit_stuffer
